box_draw_control: RTL



---
 rtl/box_draw_control.sv | 129 ++++++++++++
 1 files changed

// File: rtl/box_draw_control.sv
// Control FSM and frame-rate pacing timer for the box-drawing datapath.
// Optional macro BOX_CTRL_MOVE_GATE_EN: skip erase/move when no left/right request is present.
module box_draw_control #(
  parameter int FRAME_CYCLES    = 833333,
  parameter int FRAMES_PER_MOVE = 15,
  parameter int FRAME_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       done,
  input  logic       timer,
  input  logic       update,
  input  logic       left,
  input  logic       right,
  output logic       cnA,
  output logic       cnB,
  output logic       cnC,
  output logic       cnD,
  output logic       enable,
  output logic       plot,
  output logic       frame_tick,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    ERASE = 3'd4,
    MOVE  = 3'd5
  } state_t;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [7:0]         MOVE_LAST  = 8'(FRAMES_PER_MOVE - 1);

  state_t             state, state_next;
  logic [FRAME_W-1:0] frame_cnt;
  logic [7:0]         move_cnt, move_cnt_next;
  logic               plot_next;
  logic               count_tick;
  logic               expire;

  // Free-running frame timer, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign frame_tick = (frame_cnt == FRAME_LAST);
  assign count_tick = (state == WAIT) && frame_tick && timer;
  // The qualifying tick is the one that brings move_cnt up to FRAMES_PER_MOVE.
  assign expire     = count_tick && (move_cnt >= MOVE_LAST);
  assign plot_next  = ((state == DRAW) || (state == ERASE)) && !done;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      move_cnt <= '0;
      plot     <= 1'b0;
    end else begin
      state    <= state_next;
      move_cnt <= move_cnt_next;
      plot     <= plot_next;
    end
  end

  always_comb begin
    state_next    = state;
    move_cnt_next = move_cnt;
    cnA           = 1'b0;
    cnB           = 1'b0;
    cnC           = 1'b0;
    cnD           = 1'b0;
    enable        = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_next = DRAW;
      end
      DRAW: begin
        cnA = 1'b1;
        if (done) state_next = ARM;
      end
      ARM: begin
        cnB           = 1'b1;
        move_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        if (count_tick) begin
          move_cnt_next = (move_cnt == 8'hFF) ? move_cnt : move_cnt + 8'd1;
        end
        if (expire) begin
          enable     = 1'b1;
          state_next = ERASE;
`ifdef BOX_CTRL_MOVE_GATE_EN
          // Stationary box: restart the wait without redrawing.
          if (!left && !right) begin
            state_next    = WAIT;
            move_cnt_next = '0;
          end
`endif
        end
      end
      ERASE: begin
        cnC = 1'b1;
        if (done) state_next = MOVE;
      end
      MOVE: begin
        cnD = 1'b1;
        if (update) state_next = DRAW;
      end
      default: state_next = IDLE;
    endcase
  end

`ifndef BOX_CTRL_MOVE_GATE_EN
  logic unused_dirs;
  assign unused_dirs = left ^ right;
`endif

endmodule
